// File: rtl/sdm_pkg.sv
// Shared types for the sigma-delta stream controller: FSM state encoding,
// audio sample type and the saturating underrun counter helper.
package sdm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN
   } state_t;

   typedef logic signed [15:0] sample_t;

   localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == UNDERRUN_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sdm_tick_gen.sv
// Modulator tick generator: divides clk by CLK_DIV into ticks and counts OSR
// ticks per sample frame, flagging the first and last tick of each frame.
module sdm_tick_gen #(
   parameter int OSR     = 64,
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick,
   output logic frame_start,
   output logic frame_end
);

   // CLK_DIV may be 1, where $clog2 would give a zero-width counter.
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int OW = $clog2(OSR);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [OW-1:0] OSR_LAST = OW'(OSR - 1);

   logic [DW-1:0] div_cnt;
   logic [OW-1:0] osr_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         osr_cnt <= '0;
      end else if (!run) begin
         div_cnt <= '0;
         osr_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + OW'(1);
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   assign tick        = run && (div_cnt == DIV_LAST);
   assign frame_start = tick && (osr_cnt == '0);
   assign frame_end   = tick && (osr_cnt == OSR_LAST);

endmodule

// File: rtl/sdm_stream_ctrl.sv
// Streams upstream audio samples into a sigma-delta DAC/ADC pair: one sample
// held per OSR-tick frame, a one-entry pending buffer, and underrun counting.
module sdm_stream_ctrl
   import sdm_pkg::*;
#(
   parameter int OSR     = 64,
   parameter int CLK_DIV = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               s_valid,
   input  logic signed [15:0] s_data,
   output logic               s_ready,
   output logic               dac_valid,
   output logic signed [15:0] dac_data,
   output logic               adc_valid,
   output logic               frame_start,
   output logic [7:0]         underrun_cnt,
   input  logic               clear_underrun,
   output logic               busy
);

   logic [1:0] rst_sync;
   logic       rst_int_n;

   // NOTE: reset asserts asynchronously but releases only after two clk edges, avoiding recovery violations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   state_t     state, next_state;
   logic       pend_full;
   sample_t    pend_data, held;
   logic [7:0] underrun;
   logic       run, tick, frame_end;
   logic       prime_load, boundary, drain_done;

   sdm_tick_gen #(.OSR(OSR), .CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk         (clk),
      .rst_n       (rst_int_n),
      .run         (run),
      .tick        (tick),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) state <= ST_IDLE;
      else            state <= next_state;
   end

   // NOTE: next_state gets its default before the case so no path infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (enable) next_state = ST_PRIME;
         ST_PRIME: begin
            if (!enable)        next_state = ST_IDLE;
            else if (pend_full) next_state = ST_RUN;
         end
         ST_RUN:   if (!enable) next_state = ST_DRAIN;
         ST_DRAIN: if (frame_end) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   assign run        = (state == ST_RUN) || (state == ST_DRAIN);
   assign prime_load = (state == ST_PRIME) && enable && pend_full;
   assign boundary   = (state == ST_RUN) && frame_end;
   assign drain_done = (state == ST_DRAIN) && frame_end;

   // A full buffer drops s_ready, so a transfer never collides with a load.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         pend_full <= 1'b0;
         pend_data <= '0;
         held      <= '0;
         underrun  <= '0;
      end else begin
         if ((state == ST_IDLE) || drain_done) begin
            pend_full <= 1'b0;
            held      <= '0;
         end else if (prime_load || (boundary && pend_full)) begin
            held      <= pend_data;
            pend_full <= 1'b0;
         end else if (s_valid && s_ready) begin
            pend_full <= 1'b1;
            pend_data <= s_data;
         end

         if (clear_underrun)              underrun <= '0;
         else if (boundary && !pend_full) underrun <= sat_inc(underrun);
      end
   end

   assign s_ready      = (state != ST_IDLE) && !pend_full;
   assign busy         = (state != ST_IDLE);
   assign dac_valid    = tick;
   assign adc_valid    = tick;
   assign dac_data     = held;
   assign underrun_cnt = underrun;

endmodule
